// File: rtl/sv_sys_pkg.sv
// Shared definitions for the system timer / IRQ block at 0x2020-0x2027:
// register offsets, sys_ctl and status bit positions, prescaler width.
package sv_sys_pkg;

    localparam logic [2:0] SYS_JOY   = 3'd0;
    localparam logic [2:0] SYS_TIMER = 3'd3;
    localparam logic [2:0] SYS_TACK  = 3'd4;
    localparam logic [2:0] SYS_DACK  = 3'd5;
    localparam logic [2:0] SYS_CTL   = 3'd6;
    localparam logic [2:0] SYS_STAT  = 3'd7;

    localparam int CTL_TIM_IE = 1;
    localparam int CTL_DMA_IE = 2;
    localparam int CTL_LCD_EN = 3;
    localparam int CTL_PRESC  = 4;
    localparam int CTL_BANK   = 5;  // lsb of the 2-bit bank field [6:5]

    localparam int STAT_TIM = 0;
    localparam int STAT_DMA = 1;

    localparam int PRESC_W = 14;
    typedef logic [PRESC_W-1:0] presc_t;

    function automatic logic [1:0] ctl_bank(input logic [7:0] ctl);
        return ctl[CTL_BANK +: 2];
    endfunction

    function automatic logic ctl_lcd_en(input logic [7:0] ctl);
        return ctl[CTL_LCD_EN];
    endfunction

endpackage

// File: rtl/sv_prescaler.sv
// ce-qualified reload down-counter; tick on the ce where the count sits at 0.
// The reload period is chosen by 'slow' at the moment of reload only.
module sv_prescaler
    import sv_sys_pkg::*;
#(
    parameter int FAST = 256,
    parameter int SLOW = 16384
) (
    input  logic clk,
    input  logic reset_n,
    input  logic ce,
    input  logic load,
    input  logic slow,
    output logic tick
);

    presc_t cnt;
    presc_t reload;

    assign reload = slow ? presc_t'(SLOW - 1) : presc_t'(FAST - 1);
    assign tick   = ce & (cnt == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= reload;
        end else if (ce) begin
            cnt <= (cnt == '0) ? reload : cnt - presc_t'(1);
        end
    end

endmodule

// File: rtl/sv_sys_timer.sv
// System timer / interrupt controller for the 0x2020-0x2027 window.
// Optional NMI generator enabled by defining SV_NMI_EN.
module sv_sys_timer
    import sv_sys_pkg::*;
#(
    parameter int PRESCALE_FAST = 256,
    parameter int PRESCALE_SLOW = 16384,
    parameter int NMI_PERIOD    = 65536
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ce,
    input  logic       cs,
    input  logic       we,
    input  logic [2:0] addr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    input  logic       dma_done,
    output logic [7:0] sys_ctl,
    output logic       irq,
    output logic       nmi
);

    logic       access, rd, wr;
    logic       wr_tim, wr_ctl, tim_ack, dma_ack;
    logic       tick, tim_set;
    logic [7:0] timer;
    logic       tim_flag, dma_flag;
    logic [7:0] rd_data;

    assign access  = cs & ce;
    assign rd      = access & ~we;
    assign wr      = access & we;
    assign wr_tim  = wr & (addr == SYS_TIMER);
    assign wr_ctl  = wr & (addr == SYS_CTL);
    assign tim_ack = rd & (addr == SYS_TACK);
    assign dma_ack = rd & (addr == SYS_DACK);

    sv_prescaler #(
        .FAST (PRESCALE_FAST),
        .SLOW (PRESCALE_SLOW)
    ) u_presc (
        .clk     (clk),
        .reset_n (reset_n),
        .ce      (ce),
        .load    (wr_tim),
        .slow    (sys_ctl[CTL_PRESC]),
        .tick    (tick)
    );

    // Loading zero flags immediately; otherwise only the 1->0 step flags.
    assign tim_set = (wr_tim & (din == 8'h00)) | (tick & ~wr_tim & (timer == 8'd1));

    always_comb begin
        rd_data = 8'hFF;
        case (addr)
            SYS_JOY:   rd_data = 8'hFF;
            SYS_TIMER: rd_data = timer;
            SYS_CTL:   rd_data = sys_ctl;
            SYS_STAT: begin
                rd_data           = 8'h00;
                rd_data[STAT_TIM] = tim_flag;
                rd_data[STAT_DMA] = dma_flag;
            end
            default:   rd_data = 8'hFF;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dout     <= 8'hFF;
            sys_ctl  <= 8'h00;
            timer    <= 8'h00;
            tim_flag <= 1'b0;
            dma_flag <= 1'b0;
            irq      <= 1'b0;
        end else begin
            if (rd)
                dout <= rd_data;
            if (wr_ctl)
                sys_ctl <= din;
            if (wr_tim)
                timer <= din;
            else if (tick && timer != 8'h00)
                timer <= timer - 8'd1;
            // set beats ack when both land on the same clock
            tim_flag <= tim_set  | (tim_flag & ~tim_ack);
            dma_flag <= dma_done | (dma_flag & ~dma_ack);
            irq      <= (tim_flag & sys_ctl[CTL_TIM_IE]) | (dma_flag & sys_ctl[CTL_DMA_IE]);
        end
    end

`ifdef SV_NMI_EN
    logic [15:0] nmi_cnt;
    logic        nmi_wrap;

    assign nmi_wrap = (nmi_cnt == 16'(NMI_PERIOD - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            nmi_cnt <= 16'h0000;
            nmi     <= 1'b0;
        end else if (ce) begin
            nmi     <= nmi_wrap;
            nmi_cnt <= nmi_wrap ? 16'h0000 : nmi_cnt + 16'd1;
        end
    end
`else
    assign nmi = 1'b0;
`endif

endmodule
